// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetch/decode/execute control FSM for a small
// register-file CPU. Issues instruction and data memory handshakes, drives
// register-file write and PC load/jump/branch controls, and reports
// BUSY/HALTED/TRAP status.
// Optional build macro ILLEGAL_TRAP_EN: opcodes 1011-1110 enter a sticky
// TRAP state instead of retiring as NOP.
module instr_sequencer (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic [9:0] INSTR,
  input  logic       IMEM_ACK,
  input  logic       DMEM_ACK,
  output logic       IMEM_REQ,
  output logic       DMEM_REQ,
  output logic       DMEM_WE,
  output logic       PC_EN,
  output logic       PL,
  output logic       JB,
  output logic       BC,
  output logic       RF_WE,
  output logic [1:0] DA,
  output logic [1:0] AA,
  output logic [1:0] BA,
  output logic [3:0] FS,
  output logic       BUSY,
  output logic       HALTED,
  output logic       TRAP
);

  localparam logic [3:0] OpNop  = 4'b0000;
  localparam logic [3:0] OpAdd  = 4'b0001;
  localparam logic [3:0] OpSub  = 4'b0010;
  localparam logic [3:0] OpAnd  = 4'b0011;
  localparam logic [3:0] OpOr   = 4'b0100;
  localparam logic [3:0] OpMov  = 4'b0101;
  localparam logic [3:0] OpLd   = 4'b0110;
  localparam logic [3:0] OpSt   = 4'b0111;
  localparam logic [3:0] OpBrz  = 4'b1000;
  localparam logic [3:0] OpBrn  = 4'b1001;
  localparam logic [3:0] OpJmp  = 4'b1010;
  localparam logic [3:0] OpHalt = 4'b1111;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMemWait,
`ifdef ILLEGAL_TRAP_EN
    StTrap,
`endif
    StHalt
  } state_e;

  state_e     state_q, state_d;
  logic [9:0] ir_q, ir_d;
  logic       imem_req_q, imem_req_d;
  logic       dmem_req_q, dmem_req_d;
  logic       dmem_we_q, dmem_we_d;
  logic       pc_en_q, pc_en_d;
  logic       pl_q, pl_d;
  logic       jb_q, jb_d;
  logic       bc_q, bc_d;
  logic       rf_we_q, rf_we_d;
  logic       busy_q, busy_d;
  logic       halted_q, halted_d;
  logic       trap_d;
  logic       mem_retire;

  // Next state, IR capture, and next registered outputs decoded from the next state
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    imem_req_d = 1'b0;
    dmem_req_d = 1'b0;
    dmem_we_d  = 1'b0;
    pc_en_d    = 1'b0;
    pl_d       = 1'b0;
    jb_d       = 1'b0;
    bc_d       = 1'b0;
    rf_we_d    = 1'b0;
    busy_d     = 1'b0;
    halted_d   = 1'b0;
    trap_d     = 1'b0;

    case (state_q)
      StIdle:    if (START) state_d = StFetch;
      StFetch: begin
        if (IMEM_ACK) begin
          state_d = StDecode;
          ir_d    = INSTR;
        end
      end
      StDecode:  state_d = StExec;
      StExec: begin
        case (ir_q[9:6])
          OpLd, OpSt: state_d = StMemWait;
          OpHalt:     state_d = StHalt;
`ifdef ILLEGAL_TRAP_EN
          4'b1011, 4'b1100, 4'b1101, 4'b1110: state_d = StTrap;
`endif
          default:    state_d = StFetch;
        endcase
      end
      StMemWait: if (DMEM_ACK) state_d = StFetch;
      StHalt:    state_d = StHalt;
`ifdef ILLEGAL_TRAP_EN
      StTrap:    state_d = StTrap;
`endif
      default:   state_d = StIdle;
    endcase

    case (state_d)
      StFetch: begin
        imem_req_d = 1'b1;
        busy_d     = 1'b1;
      end
      StDecode:  busy_d = 1'b1;
      StExec: begin
        busy_d = 1'b1;
        case (ir_d[9:6])
          OpAdd, OpSub, OpAnd, OpOr, OpMov: begin
            rf_we_d = 1'b1;
            pc_en_d = 1'b1;
          end
          OpNop:  pc_en_d = 1'b1;
          OpBrz: begin
            pc_en_d = 1'b1;
            pl_d    = 1'b1;
          end
          OpBrn: begin
            pc_en_d = 1'b1;
            pl_d    = 1'b1;
            bc_d    = 1'b1;
          end
          OpJmp: begin
            pc_en_d = 1'b1;
            pl_d    = 1'b1;
            jb_d    = 1'b1;
          end
          OpLd, OpSt, OpHalt: ;
`ifdef ILLEGAL_TRAP_EN
          default: ;
`else
          // Unused opcodes retire as NOP
          default: pc_en_d = 1'b1;
`endif
        endcase
      end
      StMemWait: begin
        busy_d     = 1'b1;
        dmem_req_d = 1'b1;
        dmem_we_d  = (ir_d[9:6] == OpSt);
      end
      StHalt:    halted_d = 1'b1;
`ifdef ILLEGAL_TRAP_EN
      StTrap:    trap_d = 1'b1;
`endif
      default: ;
    endcase
  end

  // State, IR and registered output strobes
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      ir_q       <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      pc_en_q    <= 1'b0;
      pl_q       <= 1'b0;
      jb_q       <= 1'b0;
      bc_q       <= 1'b0;
      rf_we_q    <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
      pc_en_q    <= pc_en_d;
      pl_q       <= pl_d;
      jb_q       <= jb_d;
      bc_q       <= bc_d;
      rf_we_q    <= rf_we_d;
      busy_q     <= busy_d;
      halted_q   <= halted_d;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic trap_q;

  // Sticky trap flag
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) trap_q <= 1'b0;
    else        trap_q <= trap_d;
  end

  assign TRAP = trap_q;
`else
  assign TRAP = 1'b0;
`endif

  // Memory ops retire in the DMEM_ACK cycle itself, so that pulse cannot be registered
  assign mem_retire = (state_q == StMemWait) && DMEM_ACK;

  assign IMEM_REQ = imem_req_q;
  assign DMEM_REQ = dmem_req_q;
  assign DMEM_WE  = dmem_we_q;
  assign PC_EN    = pc_en_q | mem_retire;
  assign RF_WE    = rf_we_q | (mem_retire && (ir_q[9:6] == OpLd));
  assign PL       = pl_q;
  assign JB       = jb_q;
  assign BC       = bc_q;
  assign BUSY     = busy_q;
  assign HALTED   = halted_q;
  assign FS       = ir_q[9:6];
  assign DA       = ir_q[5:4];
  assign AA       = ir_q[3:2];
  assign BA       = ir_q[1:0];

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: a driver plays instruction and data
// memory, pushing the expected retirement of every fetched instruction; a
// negedge monitor pops and compares at each PC_EN pulse or HALTED/TRAP rise.
module tb_instr_sequencer;

  logic       CLK = 1'b0;
  logic       RST_N, START, IMEM_ACK, DMEM_ACK;
  logic [9:0] INSTR;
  logic       IMEM_REQ, DMEM_REQ, DMEM_WE, PC_EN, PL, JB, BC, RF_WE;
  logic [1:0] DA, AA, BA;
  logic [3:0] FS;
  logic       BUSY, HALTED, TRAP;
  logic [20:0] outs;

  instr_sequencer dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .INSTR(INSTR),
    .IMEM_ACK(IMEM_ACK), .DMEM_ACK(DMEM_ACK),
    .IMEM_REQ(IMEM_REQ), .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE),
    .PC_EN(PC_EN), .PL(PL), .JB(JB), .BC(BC), .RF_WE(RF_WE),
    .DA(DA), .AA(AA), .BA(BA), .FS(FS),
    .BUSY(BUSY), .HALTED(HALTED), .TRAP(TRAP)
  );

  always #5 CLK = ~CLK;

  assign outs = {IMEM_REQ, DMEM_REQ, DMEM_WE, PC_EN, PL, JB, BC, RF_WE,
                 DA, AA, BA, FS, BUSY, HALTED, TRAP};

  // kind: 0 retire (PC_EN pulse), 1 halt, 2 trap; ctl = {RF_WE,PL,JB,BC}
  typedef struct {
    int         kind;
    logic [9:0] instr;
    logic [3:0] ctl;
    logic [3:0] mask;
    int         lat;
    int         dreq;
    int         dwe;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int t0 = 0;
  int dreq_cnt = 0;
  int dwe_cnt = 0;
  bit halted_seen = 0;
  bit trap_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected behaviour from the opcode table; lat counts cycles after the fetch ACK cycle
  function automatic exp_t model(input logic [9:0] ins, input int dwait);
    exp_t e;
    e.kind = 0; e.instr = ins; e.ctl = 4'b0000; e.mask = 4'b1111;
    e.lat = 2; e.dreq = 0; e.dwe = 0;
    case (ins[9:6])
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5: e.ctl = 4'b1000;
      4'd0: e.ctl = 4'b0000;
      4'd6: begin e.ctl = 4'b1000; e.lat = 3 + dwait; e.dreq = dwait + 1; end
      4'd7: begin e.lat = 3 + dwait; e.dreq = dwait + 1; e.dwe = dwait + 1; end
      4'd8: e.ctl = 4'b0100;
      4'd9: e.ctl = 4'b0101;
      4'd10: begin e.ctl = 4'b0110; e.mask = 4'b1110; end
      4'd15: begin e.kind = 1; e.lat = 3; end
`ifdef ILLEGAL_TRAP_EN
      default: begin e.kind = 2; e.lat = 3; end
`else
      default: e.ctl = 4'b0000;
`endif
    endcase
    return e;
  endfunction

  task automatic check_event(input int kind);
    exp_t e;
    chk("scoreboard entry present", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("event kind", 32'(kind), 32'(e.kind));
      chk("rf_we/pl/jb/bc", 32'({RF_WE, PL, JB, BC} & e.mask), 32'(e.ctl & e.mask));
      chk("fs/da/aa/ba from ir", 32'({FS, DA, AA, BA}), 32'(e.instr));
      chk("latency after fetch ack", 32'(cyc - t0), 32'(e.lat));
      chk("dmem_req cycles", 32'(dreq_cnt), 32'(e.dreq));
      chk("dmem_we cycles", 32'(dwe_cnt), 32'(e.dwe));
    end
  endtask

  // Monitor: samples mid-cycle, after inputs and outputs have settled
  always @(negedge CLK) begin
    cyc++;
    if (!RST_N) begin
      halted_seen = 0;
      trap_seen = 0;
    end else begin
      if (IMEM_REQ && IMEM_ACK) begin
        t0 = cyc; dreq_cnt = 0; dwe_cnt = 0;
      end
      if (DMEM_REQ) dreq_cnt++;
      if (DMEM_REQ && DMEM_WE) dwe_cnt++;
      chk("imem_req and dmem_req exclusive", 32'(IMEM_REQ & DMEM_REQ), 32'd0);
      if (!PC_EN) chk("pc/rf controls low without pc_en", 32'({PL, JB, BC, RF_WE}), 32'd0);
      if (PC_EN) check_event(0);
      if (HALTED && !halted_seen) begin halted_seen = 1; check_event(1); end
      if (TRAP && !trap_seen) begin trap_seen = 1; check_event(2); end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Serve one instruction fetch (after iw wait cycles) and, for LD/ST, one data access
  task automatic run_instr(input logic [9:0] ins, input int iw, input int dw);
    int k;
    k = 0;
    while (!IMEM_REQ && k < 50) begin step(); k++; end
    chk("fetch request seen", 32'(IMEM_REQ), 32'd1);
    if (!IMEM_REQ) return;
    repeat (iw) begin
      DMEM_ACK = 1'($urandom);
      START = 1'($urandom);
      step();
    end
    INSTR = ins;
    IMEM_ACK = 1'b1;
    sb.push_back(model(ins, dw));
    step();
    IMEM_ACK = 1'b0;
    DMEM_ACK = 1'b0;
    START = 1'b0;
    INSTR = 10'($urandom);
    if (ins[9:6] == 4'd6 || ins[9:6] == 4'd7) begin
      k = 0;
      while (!DMEM_REQ && k < 50) begin
        IMEM_ACK = 1'($urandom);
        step();
        k++;
      end
      chk("data request seen", 32'(DMEM_REQ), 32'd1);
      if (!DMEM_REQ) begin IMEM_ACK = 1'b0; return; end
      repeat (dw) begin
        IMEM_ACK = 1'($urandom);
        step();
      end
      IMEM_ACK = 1'b0;
      DMEM_ACK = 1'b1;
      step();
      DMEM_ACK = 1'b0;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() > 0 && k < 60) begin step(); k++; end
    chk("scoreboard drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [3:0] op;
    RST_N = 1'b0; START = 1'b1; IMEM_ACK = 1'b1; DMEM_ACK = 1'b1; INSTR = 10'h3ff;
    #12;
    chk("outputs during reset", 32'(outs), 32'd0);
    repeat (2) step();
    chk("reset overrides start", 32'(outs), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1; START = 1'b0; IMEM_ACK = 1'b0; DMEM_ACK = 1'b0;
    step();
    chk("idle busy after reset", 32'(BUSY), 32'd0);
    START = 1'b1;
    step();
    START = 1'b0;
    chk("imem_req one cycle after start", 32'(IMEM_REQ), 32'd1);
    chk("busy in fetch", 32'(BUSY), 32'd1);

    // Directed: ALU op, delayed LD, ST, branch trio
    run_instr(10'b0001_01_10_11, 0, 0);
    run_instr(10'b0110_10_01_00, 0, 3);
    run_instr(10'b0111_00_11_01, 1, 1);
    run_instr(10'b1000_01_00_10, 0, 0);
    run_instr(10'b1001_11_01_01, 0, 0);
    run_instr(10'b1010_10_10_11, 0, 0);

    // Random instruction stream with random memory wait states
    for (int i = 0; i < 60; i++) begin
`ifdef ILLEGAL_TRAP_EN
      op = 4'($urandom_range(0, 10));
`else
      op = 4'($urandom_range(0, 14));
`endif
      run_instr({op, 6'($urandom)}, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end
    drain();

    // Asynchronous reset in the middle of a fetch, then a stray ACK
    begin
      int k;
      k = 0;
      while (!IMEM_REQ && k < 20) begin step(); k++; end
      chk("fetch pending before reset", 32'(IMEM_REQ), 32'd1);
    end
    #3;
    RST_N = 1'b0;
    IMEM_ACK = 1'b1;
    INSTR = 10'b0001_11_11_11;
    #1;
    chk("async reset mid-fetch", 32'(outs), 32'd0);
    step();
    RST_N = 1'b1;
    repeat (3) begin
      step();
      chk("stray imem_ack ignored in idle", 32'({IMEM_REQ, BUSY, PC_EN}), 32'd0);
    end
    IMEM_ACK = 1'b0;
    chk("nothing expected after reset", 32'(sb.size()), 32'd0);

    START = 1'b1;
    step();
    START = 1'b0;
    run_instr(10'b0101_00_01_10, 0, 0);
    run_instr(10'b0110_11_00_00, 1, 0);
    run_instr(10'b1100_01_01_01, 0, 0);
`ifdef ILLEGAL_TRAP_EN
    repeat (4) step();
    chk("trap asserted", 32'(TRAP), 32'd1);
    START = 1'b1;
    repeat (3) step();
    START = 1'b0;
    chk("trap holds, start ignored", 32'({TRAP, IMEM_REQ, BUSY}), 32'b100);
`else
    run_instr(10'b1111_00_00_00, 0, 0);
    repeat (4) step();
    chk("halted with busy low", 32'({HALTED, BUSY, TRAP}), 32'b100);
    START = 1'b1;
    repeat (3) step();
    START = 1'b0;
    chk("halt holds, start ignored", 32'({HALTED, IMEM_REQ, BUSY}), 32'b100);
`endif
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
